// File: rtl/approx_pkg.sv
// Shared definitions for the approximate-adder error monitors.
package approx_pkg;

  // Default operand / sum width of the monitored adders.
  localparam int N_DEF     = 16;
  // Default width of sample counters and batch length.
  localparam int CNT_W_DEF = 16;
  // Default width of the saturating error-distance accumulator.
  localparam int ACC_W_DEF = 32;
  // Guard bits added to N for the signed difference exact - approx.
  localparam int ED_GUARD  = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Width of the signed difference used to form the error distance.
  function automatic int ed_diff_w(input int n);
    return n + ED_GUARD;
  endfunction

endpackage

// File: rtl/err_distance.sv
// Two-stage datapath: S1 registers the exact N-bit sum and the approximate
// sum, S2 registers |exact - approx| and the error flag.
module err_distance
  import approx_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [N-1:0] approx_sum,
  output logic         s1_valid,
  output logic         s2_valid,
  output logic [N-1:0] ed,
  output logic         err
);

  localparam int DW = ed_diff_w(N);

  logic [N-1:0]         s1_exact;
  logic [N-1:0]         s1_approx;
  logic signed [DW-1:0] diff;
  logic [N-1:0]         diff_lo;
  logic [N-1:0]         mag;

  // Signed difference; the magnitude always fits in N bits, so the sign bit
  // only selects between the low bits and their two's complement.
  always_comb begin
    diff    = $signed({1'b0, s1_exact}) - $signed({1'b0, s1_approx});
    diff_lo = diff[N-1:0];
    mag     = diff[DW-1] ? (~diff_lo + N'(1)) : diff_lo;
  end

  // S1: exact sum with the carry-out dropped, alongside the approximate sum.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_exact  <= '0;
      s1_approx <= '0;
    end else begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_exact  <= a + b;
        s1_approx <= approx_sum;
      end
    end
  end

  // S2: error distance and error flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      ed       <= '0;
      err      <= 1'b0;
    end else begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        ed  <= mag;
        err <= |mag;
      end
    end
  end

endmodule

// File: rtl/approx_err_monitor.sv
// Batch error-metric collector for approximate adders: counts erroneous
// samples, sums error distances (saturating) and tracks the largest one.
//
// state | meaning
// IDLE  | waiting for start, no batch yet
// RUN   | accepting samples until num_samples have been taken
// DRAIN | flushing the two-stage pipeline into the accumulators
// DONE  | results stable; start launches a new batch
module approx_err_monitor
  import approx_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int CNT_W = CNT_W_DEF,
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] num_samples,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     a,
  input  logic [N-1:0]     b,
  input  logic [N-1:0]     approx_sum,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] sample_count,
  output logic [CNT_W-1:0] err_count,
  output logic [ACC_W-1:0] ed_sum,
  output logic [N-1:0]     ed_max
);

  state_t           state;
  logic [CNT_W-1:0] num_lat;
  logic [CNT_W-1:0] acc_cnt;
  logic             accept;
  logic             s1_valid;
  logic             s2_valid;
  logic [N-1:0]     ed;
  logic             err;
  logic [ACC_W:0]   sum_ext;
  logic [ACC_W-1:0] sum_sat;

  assign accept = in_valid && in_ready;

  err_distance #(.N(N)) u_err_distance (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (accept),
    .a          (a),
    .b          (b),
    .approx_sum (approx_sum),
    .s1_valid   (s1_valid),
    .s2_valid   (s2_valid),
    .ed         (ed),
    .err        (err)
  );

  // One extra bit catches the carry so the accumulator clamps instead of wrapping.
  always_comb begin
    sum_ext = {1'b0, ed_sum} + {{(ACC_W + 1 - N){1'b0}}, ed};
    sum_sat = sum_ext[ACC_W] ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
  end

  // Batch FSM with registered handshake/status outputs and the accumulators.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      num_lat      <= '0;
      acc_cnt      <= '0;
      in_ready     <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      sample_count <= '0;
      err_count    <= '0;
      ed_sum       <= '0;
      ed_max       <= '0;
    end else begin
      if (s2_valid) begin
        sample_count <= sample_count + CNT_W'(1);
        err_count    <= err_count + CNT_W'(err);
        ed_sum       <= sum_sat;
        if (ed > ed_max) ed_max <= ed;
      end
      case (state)
        IDLE, DONE: begin
          if (start) begin
            num_lat      <= num_samples;
            acc_cnt      <= '0;
            sample_count <= '0;
            err_count    <= '0;
            ed_sum       <= '0;
            ed_max       <= '0;
            if (num_samples == '0) begin
              state    <= DONE;
              in_ready <= 1'b0;
              busy     <= 1'b0;
              done     <= 1'b1;
            end else begin
              state    <= RUN;
              in_ready <= 1'b1;
              busy     <= 1'b1;
              done     <= 1'b0;
            end
          end
        end
        RUN: begin
          if (accept) begin
            acc_cnt <= acc_cnt + CNT_W'(1);
            if (acc_cnt + CNT_W'(1) == num_lat) begin
              in_ready <= 1'b0;
              state    <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (!s1_valid && !s2_valid) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
